fu_sequencer: RTL and testbench
===============================

# fu_sequencer

Synthesizable stimulus/check sequencer: the hardware counterpart that drives the `Functional_Unit` operand and control inputs and checks its result. It pulls test vectors over a valid/ready stream, applies each vector to the FU, and waits a programmable settle time. It then samples `F`, compares it against the vector's golden byte, and counts mismatches. It sits between a pattern source (ROM or host FIFO) and one `Functional_Unit` instance, for on-board self-test.

## Interface
- `NUM_VEC`, default 256: vectors per run, range 1..511.
- `SETTLE`, default 1: cycles operands are held before `F` is sampled, minimum 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `vec_valid`  in  1  vector available.
- `vec_ready`  out  1  sequencer accepts the vector this cycle.
- `vec_a`, `vec_b`, `vec_c`  in  8 each  operands.
- `vec_instr`  in  8  FU instruction.
- `vec_sel`  in  3  FU select.
- `vec_golden`  in  8  expected `F`.
- `fu_a`, `fu_b`, `fu_c`  out  8 each  registered operands to the FU.
- `fu_instruction`  out  8  registered instruction to the FU.
- `fu_select`  out  3  registered select to the FU.
- `fu_f`  in  8  FU result; combinational path from the `fu_*` outputs.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next `start` or `rst`.
- `mismatch`  out  1  one-cycle pulse on each failing compare.
- `err_count`  out  9  mismatches in the current run; saturates at 511.
- `fail_idx`  out  9  index (0-based) of the first failing vector.
- `vec_idx`  out  9  index of the vector currently being applied or checked.

## Operation
- States are IDLE, FETCH, SETTLE, CHECK and DONE.
- **IDLE**
  - Outputs hold.
  - `start` moves to FETCH and clears `err_count`, `fail_idx`, `vec_idx` and `done`.
- **FETCH**
  - `vec_ready`=1.
  - On `vec_valid`&&`vec_ready`: load `fu_*` from `vec_*`, latch `vec_golden`, load the settle counter with `SETTLE`-1, go to SETTLE.
  - Without `vec_valid`: stay in FETCH, with `fu_*` holding the previous vector.
- **SETTLE**
  - `fu_*` held stable.
  - Counter decrements each cycle; at 0, go to CHECK.
- **CHECK** (sample `fu_f`, compare with the latched golden)
  - Compare is full 8-bit equality; X/Z on `fu_f` in simulation counts as a mismatch (`!==` semantics in the bench model only).
  - Mismatch: pulse `mismatch`, increment `err_count` (saturating). If this is the first mismatch, `fail_idx`←`vec_idx`.
  - If `vec_idx`==`NUM_VEC`-1, go to DONE; otherwise increment `vec_idx` and go to FETCH.
- **DONE**
  - `done`=1, `busy`=0, `vec_ready`=0.
  - `start` restarts the run exactly as from IDLE.
- `busy`=1 in FETCH, SETTLE and CHECK.
- `start` is ignored while `busy`.
- `fail_idx` has no meaning when `err_count`==0.

## Timing
- Reset values: state IDLE; all `fu_*`=0, `vec_ready`=0, `busy`=0, `done`=0, `mismatch`=0, `err_count`=0, `fail_idx`=0, `vec_idx`=0.
- `rst` asserted mid-run aborts immediately to the reset values; there is no partial `done`.
- Handshake cycle T: `fu_*` valid from T+1. With `SETTLE`=1, `fu_f` is sampled at the T+2 edge, and `mismatch` and `err_count` update visibly in cycle T+2.
- Per-vector throughput: `SETTLE`+2 cycles with `vec_valid` held high. A 256-vector run with `SETTLE`=1 takes 768 cycles from the first handshake to `done`.
- `done` rises in the cycle after the final CHECK.
- `vec_ready` is registered (Moore) and never depends combinationally on `vec_valid`.
- `vec_*` are sampled only at the handshake edge and may change freely otherwise.

## Configuration
- `FU_SEQ_STOP_ON_ERR_EN`
  - Defined: a mismatch in CHECK goes directly to DONE. `err_count`=1, `fail_idx`=`vec_idx`, and no further vectors are accepted.
  - Undefined: the run always completes `NUM_VEC` vectors and counts every mismatch.

## Test plan
- All-match run: `NUM_VEC`=4, `SETTLE`=1, FU model always equals golden, `vec_valid` tied 1 -> `done` at cycle 13 after `start` (1 IDLE + 12), `err_count`=0, `mismatch` never pulses.
- Injected errors: vectors 2 and 5 of 8 have wrong golden (e.g. golden=8'hFF, `fu_f`=8'h00) -> two `mismatch` pulses, `err_count`=2, `fail_idx`=2; with `FU_SEQ_STOP_ON_ERR_EN`: `done` after vector 2, `err_count`=1.
- Back-pressure: `vec_valid` low for 5 cycles before vector 1 -> FSM waits in FETCH, `fu_*` hold vector 0 values, no extra compares, final result unchanged.
- Settle: `SETTLE`=3, FU model with 2-cycle output delay -> no mismatches. Same FU model with `SETTLE`=1 -> every vector whose result differs from the previous vector's result mismatches.
- Reset mid-run: assert `rst` in SETTLE of vector 3 -> all outputs return to reset values within the same cycle. Then `start` -> `vec_idx` restarts at 0.
- Restart after done: `start` while `done`=1 -> `done`, `err_count` and `fail_idx` clear, `busy`=1 next cycle. `start` pulses while `busy` are ignored.

Source files
------------

// File: rtl/fu_sequencer.sv
// -----------------------------------------------------------------------------
// fu_sequencer
//
// Stimulus/check sequencer for one Functional_Unit. It pulls test vectors from
// a valid/ready stream and drives them onto the FU operand and control inputs.
// After a programmable settle time it samples the FU result, compares it with
// the vector's golden byte, and counts mismatches.
//
// Parameters:
//   NUM_VEC  vectors per run (1..511)
//   SETTLE   cycles the operands are held before fu_f is sampled (>= 1)
//
// Configuration macro:
//   FU_SEQ_STOP_ON_ERR_EN  when defined, the first mismatch ends the run.
//                          The default build counts every mismatch over the
//                          full run.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 one-cycle pulse that begins a run (ignored while busy)
//   vec_valid / vec_ready vector stream handshake (vec_ready is Moore)
//   vec_a/b/c, vec_instr,
//   vec_sel, vec_golden   vector payload, sampled only at the handshake edge
//   fu_a/b/c,
//   fu_instruction,
//   fu_select             registered drive to the FU
//   fu_f                  FU result (combinational from the fu_* outputs)
//   busy, done            run in progress / run finished (done held)
//   mismatch              one-cycle pulse per failing compare
//   err_count             mismatches in the current run, saturating at 511
//   fail_idx              index of the first failing vector
//   vec_idx               index of the vector being applied or checked
// -----------------------------------------------------------------------------
module fu_sequencer #(
  parameter int NUM_VEC = 256,
  parameter int SETTLE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vec_valid,
  output logic       vec_ready,
  input  logic [7:0] vec_a,
  input  logic [7:0] vec_b,
  input  logic [7:0] vec_c,
  input  logic [7:0] vec_instr,
  input  logic [2:0] vec_sel,
  input  logic [7:0] vec_golden,
  output logic [7:0] fu_a,
  output logic [7:0] fu_b,
  output logic [7:0] fu_c,
  output logic [7:0] fu_instruction,
  output logic [2:0] fu_select,
  input  logic [7:0] fu_f,
  output logic       busy,
  output logic       done,
  output logic       mismatch,
  output logic [8:0] err_count,
  output logic [8:0] fail_idx,
  output logic [8:0] vec_idx
);

  // The settle counter only ever holds SETTLE-1 .. 0.
  localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [8:0]        LAST_IDX    = 9'(NUM_VEC - 1);
  localparam logic [8:0]        ERR_MAX     = 9'h1FF;

`ifdef FU_SEQ_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       golden_q;
  logic [CNT_W-1:0] cnt_q;

  logic start_run;   // start honoured only when not busy
  logic accept;      // vector handshake this cycle
  logic sample_now;  // last settle cycle: fu_f is compared at the closing edge
  logic miscompare;
  logic last_vec;
  logic stop_now;

  assign start_run  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept     = (state_q == S_FETCH) && vec_valid;
  assign sample_now = (state_q == S_SETTLE) && (cnt_q == '0);
  assign miscompare = (fu_f != golden_q);
  assign last_vec   = (vec_idx == LAST_IDX);
  // The registered mismatch pulse is visible during CHECK, so it steers the
  // early exit without a second compare.
  assign stop_now   = STOP_ON_ERR & mismatch;

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering
  // dependent races between always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs
  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        if (vec_valid) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (last_vec || stop_now) state_d = S_DONE;
        else                      state_d = S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: FU drive, golden latch, settle counter, result bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_a           <= '0;
      fu_b           <= '0;
      fu_c           <= '0;
      fu_instruction <= '0;
      fu_select      <= '0;
      golden_q       <= '0;
      cnt_q          <= '0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      fail_idx       <= '0;
      vec_idx        <= '0;
    end else begin
      mismatch <= 1'b0;

      if (start_run) begin
        err_count <= '0;
        fail_idx  <= '0;
        vec_idx   <= '0;
      end

      if (accept) begin
        fu_a           <= vec_a;
        fu_b           <= vec_b;
        fu_c           <= vec_c;
        fu_instruction <= vec_instr;
        fu_select      <= vec_sel;
        golden_q       <= vec_golden;
        cnt_q          <= SETTLE_LOAD;
      end

      if ((state_q == S_SETTLE) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      // Compare at the edge that enters CHECK, so the pulse and the updated
      // count are visible for the whole CHECK cycle.
      if (sample_now && miscompare) begin
        mismatch <= 1'b1;
        if (err_count != ERR_MAX) err_count <= err_count + 9'd1;
        // err_count saturates and never wraps, so zero marks the first error.
        if (err_count == '0)      fail_idx  <= vec_idx;
      end

      if ((state_q == S_CHECK) && !last_vec && !stop_now) begin
        vec_idx <= vec_idx + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_fu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fu_sequencer
//
// Directed bench for fu_sequencer. Two instances are used:
//   dut_a  NUM_VEC=8, SETTLE=1  FU model selectable: combinational or 2-cycle
//   dut_b  NUM_VEC=4, SETTLE=3  FU model with a 2-cycle output delay
// The FU model is F = (A + B) ^ C. Cycle numbers below count rising edges
// after the cycle in which start is driven (that cycle is cycle 0), with
// outputs observed 1 ns after each edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fu_sequencer;

  localparam int NA = 8;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- dut_a ----------------
  logic       a_rst, a_start, a_valid, a_ready;
  logic [7:0] a_va, a_vb, a_vc, a_vi, a_vg;
  logic [2:0] a_vs;
  logic [7:0] a_fa, a_fb, a_fc, a_fi, a_ff;
  logic [2:0] a_fs;
  logic       a_busy, a_done, a_mis;
  logic [8:0] a_err, a_fidx, a_vidx;
  logic       a_mode;                   // 0: combinational FU, 1: delayed FU
  logic [7:0] a_d1 = '0, a_d2 = '0;

  // ---------------- dut_b ----------------
  logic       b_rst, b_start, b_valid, b_ready;
  logic [7:0] b_va, b_vb, b_vc, b_vi, b_vg;
  logic [2:0] b_vs;
  logic [7:0] b_fa, b_fb, b_fc, b_fi, b_ff;
  logic [2:0] b_fs;
  logic       b_busy, b_done, b_mis;
  logic [8:0] b_err, b_fidx, b_vidx;
  logic [7:0] b_d1 = '0, b_d2 = '0;

  function automatic logic [7:0] fu_model(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] z);
    return (x + y) ^ z;
  endfunction

  assign a_ff = a_mode ? a_d2 : fu_model(a_fa, a_fb, a_fc);
  assign b_ff = b_d2;

  always @(posedge clk) begin
    a_d1 <= fu_model(a_fa, a_fb, a_fc);
    a_d2 <= a_d1;
    b_d1 <= fu_model(b_fa, b_fb, b_fc);
    b_d2 <= b_d1;
  end

  fu_sequencer #(.NUM_VEC(NA), .SETTLE(1)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start),
    .vec_valid(a_valid), .vec_ready(a_ready),
    .vec_a(a_va), .vec_b(a_vb), .vec_c(a_vc),
    .vec_instr(a_vi), .vec_sel(a_vs), .vec_golden(a_vg),
    .fu_a(a_fa), .fu_b(a_fb), .fu_c(a_fc),
    .fu_instruction(a_fi), .fu_select(a_fs), .fu_f(a_ff),
    .busy(a_busy), .done(a_done), .mismatch(a_mis),
    .err_count(a_err), .fail_idx(a_fidx), .vec_idx(a_vidx)
  );

  fu_sequencer #(.NUM_VEC(NB), .SETTLE(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start),
    .vec_valid(b_valid), .vec_ready(b_ready),
    .vec_a(b_va), .vec_b(b_vb), .vec_c(b_vc),
    .vec_instr(b_vi), .vec_sel(b_vs), .vec_golden(b_vg),
    .fu_a(b_fa), .fu_b(b_fb), .fu_c(b_fc),
    .fu_instruction(b_fi), .fu_select(b_fs), .fu_f(b_ff),
    .busy(b_busy), .done(b_done), .mismatch(b_mis),
    .err_count(b_err), .fail_idx(b_fidx), .vec_idx(b_vidx)
  );

  // Vector table. Vector 3 repeats vector 2's operands. With injection,
  // vectors 2 and 5 carry A=B=C=0 (F=00) against golden FF.
  logic [7:0] ra[NA], rb[NA], rc[NA], ri[NA], rg[NA];
  logic [2:0] rs[NA];

  int a_ptr, b_ptr;
  int cyc, done_cyc, mis_n, mis_first, mis_second, hold_viol;

  // Per-cycle trace of dut_a, indexed by cycle number.
  logic       done_at[64], busy_at[64], ready_at[64], mis_at[64];
  logic [8:0] err_at[64], fidx_at[64], vidx_at[64];

  task automatic load_rom(input bit inject);
    for (int i = 0; i < NA; i++) begin
      ra[i] = 8'(17 * i + 3);
      rb[i] = 8'(40 + 9 * i);
      rc[i] = 8'(i * i);
      ri[i] = 8'(160 + i);
      rs[i] = 3'(7 - i);
    end
    ra[3] = ra[2]; rb[3] = rb[2]; rc[3] = rc[2];
    if (inject) begin
      ra[2] = 8'h00; rb[2] = 8'h00; rc[2] = 8'h00;
      ra[5] = 8'h00; rb[5] = 8'h00; rc[5] = 8'h00;
    end
    for (int i = 0; i < NA; i++) rg[i] = fu_model(ra[i], rb[i], rc[i]);
    if (inject) begin
      rg[2] = 8'hFF;
      rg[5] = 8'hFF;
    end
  endtask

  // Present the current vector while valid; junk otherwise so that any
  // sampling outside the handshake shows up on fu_*.
  task automatic present_a();
    if (a_valid && a_ptr < NA) begin
      a_va = ra[a_ptr]; a_vb = rb[a_ptr]; a_vc = rc[a_ptr];
      a_vi = ri[a_ptr]; a_vs = rs[a_ptr]; a_vg = rg[a_ptr];
    end else begin
      a_va = 8'hEE; a_vb = 8'hEE; a_vc = 8'hEE;
      a_vi = 8'hEE; a_vs = 3'h5;  a_vg = 8'hEE;
    end
  endtask

  task automatic present_b();
    if (b_valid && b_ptr < NB) begin
      b_va = ra[b_ptr]; b_vb = rb[b_ptr]; b_vc = rc[b_ptr];
      b_vi = ri[b_ptr]; b_vs = rs[b_ptr]; b_vg = rg[b_ptr];
    end else begin
      b_va = 8'hEE; b_vb = 8'hEE; b_vc = 8'hEE;
      b_vi = 8'hEE; b_vs = 3'h5;  b_vg = 8'hEE;
    end
  endtask

  task automatic do_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    present_a(); present_b();
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Run dut_a from a start pulse in cycle 0 until done or the cycle budget.
  // valid drops for stall_len cycles from cycle stall_at; extra start pulses
  // are driven in cycles ign1 and ign2 (use -1 for none).
  task automatic run_a(input int stall_at, input int stall_len,
                       input int ign1, input int ign2, input int budget);
    logic hs;
    a_ptr = 0; cyc = 0; done_cyc = -1;
    mis_n = 0; mis_first = -1; mis_second = -1; hold_viol = 0;
    a_valid = 1'b1; a_start = 1'b1;
    present_a();
    while (done_cyc < 0 && cyc < budget) begin
      hs = a_valid && a_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) a_ptr++;
      a_start = (cyc == ign1) || (cyc == ign2);
      a_valid = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
      present_a();
      done_at[cyc]  = a_done;  busy_at[cyc] = a_busy; ready_at[cyc] = a_ready;
      mis_at[cyc]   = a_mis;   err_at[cyc]  = a_err;  fidx_at[cyc]  = a_fidx;
      vidx_at[cyc]  = a_vidx;
      if (a_mis === 1'b1) begin
        mis_n++;
        if (mis_first < 0)       mis_first  = cyc;
        else if (mis_second < 0) mis_second = cyc;
      end
      if (!a_valid && (a_fa !== ra[0] || a_fb !== rb[0] || a_fc !== rc[0] ||
                       a_fi !== ri[0] || a_fs !== rs[0] || a_ready !== 1'b1))
        hold_viol++;
      if (a_done === 1'b1) done_cyc = cyc;
    end
    a_start = 1'b0; a_valid = 1'b0;
    present_a();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_fa, a_fb, a_fc, a_fi, a_fs} !== 35'd0) begin
      failures++; $display("FAIL reset_fu_outputs: got %h expected 0", {a_fa, a_fb, a_fc, a_fi, a_fs});
    end
    checks++;
    if ({a_ready, a_busy, a_done, a_mis} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {a_ready, a_busy, a_done, a_mis});
    end
    checks++;
    if ({a_err, a_fidx, a_vidx} !== 27'd0) begin
      failures++; $display("FAIL reset_counters: got %h expected 0", {a_err, a_fidx, a_vidx});
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_mis, b_err, b_vidx} !== 22'd0) begin
      failures++; $display("FAIL reset_dut_b: got %h expected 0", {b_ready, b_busy, b_done, b_mis, b_err, b_vidx});
    end
  endtask

  // 8 vectors x 3 cycles after the start cycle: done first seen in cycle 25.
  task automatic test_all_match();
    a_mode = 1'b0;
    load_rom(1'b0);
    run_a(0, 0, -1, -1, 60);
    checks++;
    if (done_cyc !== 25) begin
      failures++; $display("FAIL all_match_done_cycle: got %0d expected 25", done_cyc);
    end
    checks++;
    if (mis_n !== 0) begin
      failures++; $display("FAIL all_match_pulses: got %0d expected 0", mis_n);
    end
    checks++;
    if (a_err !== 9'd0) begin
      failures++; $display("FAIL all_match_err_count: got %0d expected 0", a_err);
    end
    checks++;
    if (ready_at[1] !== 1'b1 || busy_at[1] !== 1'b1) begin
      failures++; $display("FAIL all_match_fetch_flags: got ready=%b busy=%b expected 1 1", ready_at[1], busy_at[1]);
    end
    checks++;
    if (ready_at[2] !== 1'b0 || busy_at[2] !== 1'b1) begin
      failures++; $display("FAIL all_match_settle_flags: got ready=%b busy=%b expected 0 1", ready_at[2], busy_at[2]);
    end
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_vidx !== 9'd7) begin
      failures++; $display("FAIL all_match_done_state: got busy=%b ready=%b vec_idx=%0d expected 0 0 7", a_busy, a_ready, a_vidx);
    end
    checks++;
    if (a_fa !== ra[7] || a_fi !== ri[7] || a_fs !== rs[7]) begin
      failures++; $display("FAIL all_match_last_vector: got a=%h instr=%h sel=%h expected %h %h %h", a_fa, a_fi, a_fs, ra[7], ri[7], rs[7]);
    end
  endtask

  // Vector 2 handshakes at the edge ending cycle 7, so its mismatch is
  // visible in cycle 9; vector 5 in cycle 18.
  task automatic test_injected();
    load_rom(1'b1);
    run_a(0, 0, -1, -1, 60);
    checks++;
    if (err_at[8] !== 9'd0 || err_at[9] !== 9'd1) begin
      failures++; $display("FAIL inject_err_timing: got c8=%0d c9=%0d expected 0 1", err_at[8], err_at[9]);
    end
    checks++;
    if (mis_at[9] !== 1'b1 || mis_at[10] !== 1'b0) begin
      failures++; $display("FAIL inject_pulse_width: got c9=%b c10=%b expected 1 0", mis_at[9], mis_at[10]);
    end
    checks++;
    if (a_fidx !== 9'd2) begin
      failures++; $display("FAIL inject_fail_idx: got %0d expected 2", a_fidx);
    end
`ifdef FU_SEQ_STOP_ON_ERR_EN
    checks++;
    if (done_cyc !== 10 || mis_n !== 1 || a_err !== 9'd1) begin
      failures++; $display("FAIL inject_stop: got done=%0d pulses=%0d err=%0d expected 10 1 1", done_cyc, mis_n, a_err);
    end
    checks++;
    if (a_vidx !== 9'd2 || a_ptr !== 3) begin
      failures++; $display("FAIL inject_stop_accepts: got vec_idx=%0d accepted=%0d expected 2 3", a_vidx, a_ptr);
    end
`else
    checks++;
    if (done_cyc !== 25 || mis_n !== 2 || a_err !== 9'd2) begin
      failures++; $display("FAIL inject_totals: got done=%0d pulses=%0d err=%0d expected 25 2 2", done_cyc, mis_n, a_err);
    end
    checks++;
    if (mis_second !== 18) begin
      failures++; $display("FAIL inject_second_pulse: got %0d expected 18", mis_second);
    end
`endif
  endtask

  // Starts from DONE with err_count/fail_idx nonzero; start pulses in cycles
  // 3 and 7 arrive while busy and must not disturb the run.
  task automatic test_restart();
    load_rom(1'b0);
    run_a(0, 0, 3, 7, 60);
    checks++;
    if (done_at[1] !== 1'b0 || busy_at[1] !== 1'b1) begin
      failures++; $display("FAIL restart_flags: got done=%b busy=%b expected 0 1", done_at[1], busy_at[1]);
    end
    checks++;
    if (err_at[1] !== 9'd0 || fidx_at[1] !== 9'd0) begin
      failures++; $display("FAIL restart_clear: got err=%0d fail_idx=%0d expected 0 0", err_at[1], fidx_at[1]);
    end
    checks++;
    if (done_cyc !== 25 || vidx_at[7] !== 9'd2) begin
      failures++; $display("FAIL restart_ignore_busy_start: got done=%0d vec_idx@7=%0d expected 25 2", done_cyc, vidx_at[7]);
    end
    checks++;
    if (a_err !== 9'd0 || mis_n !== 0) begin
      failures++; $display("FAIL restart_result: got err=%0d pulses=%0d expected 0 0", a_err, mis_n);
    end
  endtask

  // valid low in cycles 4..8 (FETCH of vector 1): run finishes 5 cycles late.
  task automatic test_back_pressure();
    do_reset();
    load_rom(1'b0);
    run_a(4, 5, -1, -1, 60);
    checks++;
    if (hold_viol !== 0) begin
      failures++; $display("FAIL backpressure_hold: got %0d bad cycles expected 0", hold_viol);
    end
    checks++;
    if (vidx_at[8] !== 9'd1) begin
      failures++; $display("FAIL backpressure_vec_idx: got %0d expected 1", vidx_at[8]);
    end
    checks++;
    if (done_cyc !== 30 || mis_n !== 0 || a_err !== 9'd0) begin
      failures++; $display("FAIL backpressure_result: got done=%0d pulses=%0d err=%0d expected 30 0 0", done_cyc, mis_n, a_err);
    end
  endtask

  // SETTLE=1 against a 2-cycle FU: each compare sees the previous vector's
  // result (0 before vector 0). Only vector 3 equals its predecessor.
  task automatic test_settle_delay();
    do_reset();
    a_mode = 1'b1;
    load_rom(1'b0);
    run_a(0, 0, -1, -1, 60);
    a_mode = 1'b0;
    checks++;
    if (a_fidx !== 9'd0) begin
      failures++; $display("FAIL settle_short_fail_idx: got %0d expected 0", a_fidx);
    end
`ifdef FU_SEQ_STOP_ON_ERR_EN
    checks++;
    if (done_cyc !== 4 || a_err !== 9'd1) begin
      failures++; $display("FAIL settle_short_stop: got done=%0d err=%0d expected 4 1", done_cyc, a_err);
    end
`else
    checks++;
    if (done_cyc !== 25 || mis_n !== 7 || a_err !== 9'd7) begin
      failures++; $display("FAIL settle_short_count: got done=%0d pulses=%0d err=%0d expected 25 7 7", done_cyc, mis_n, a_err);
    end
`endif
  endtask

  // SETTLE=3 against the same 2-cycle FU: 5 cycles per vector, no mismatches.
  task automatic test_settle_b();
    logic hs;
    int   c, dc, mn;
    do_reset();
    load_rom(1'b0);
    b_ptr = 0; c = 0; dc = -1; mn = 0;
    b_valid = 1'b1; b_start = 1'b1;
    present_b();
    while (dc < 0 && c < 60) begin
      hs = b_valid && b_ready;
      @(posedge clk);
      #1;
      c++;
      if (hs) b_ptr++;
      b_start = 1'b0;
      present_b();
      if (b_mis === 1'b1) mn++;
      if (b_done === 1'b1) dc = c;
    end
    b_valid = 1'b0;
    present_b();
    checks++;
    if (dc !== 21) begin
      failures++; $display("FAIL settle_long_done_cycle: got %0d expected 21", dc);
    end
    checks++;
    if (mn !== 0 || b_err !== 9'd0 || b_vidx !== 9'd3) begin
      failures++; $display("FAIL settle_long_result: got pulses=%0d err=%0d vec_idx=%0d expected 0 0 3", mn, b_err, b_vidx);
    end
  endtask

  // Vector 3 is in SETTLE during cycle 11; reset is asserted there.
  task automatic test_reset_mid_run();
    do_reset();
    load_rom(1'b1);
    run_a(0, 0, -1, -1, 11);
    checks++;
`ifdef FU_SEQ_STOP_ON_ERR_EN
    if (a_done !== 1'b1 || a_err !== 9'd1) begin
      failures++; $display("FAIL midrun_pre_state: got done=%b err=%0d expected 1 1", a_done, a_err);
    end
`else
    if (a_busy !== 1'b1 || a_err !== 9'd1 || a_fa !== ra[3]) begin
      failures++; $display("FAIL midrun_pre_state: got busy=%b err=%0d a=%h expected 1 1 %h", a_busy, a_err, a_fa, ra[3]);
    end
`endif
    a_rst = 1'b1;
    #1;
    checks++;
    if ({a_fa, a_fb, a_fc, a_fi, a_fs, a_ready, a_busy, a_done, a_mis, a_err, a_fidx, a_vidx} !== 66'd0) begin
      failures++; $display("FAIL midrun_async_clear: got %h expected 0",
                           {a_fa, a_fb, a_fc, a_fi, a_fs, a_ready, a_busy, a_done, a_mis, a_err, a_fidx, a_vidx});
    end
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    load_rom(1'b0);
    run_a(0, 0, -1, -1, 60);
    checks++;
    if (vidx_at[1] !== 9'd0 || vidx_at[4] !== 9'd1) begin
      failures++; $display("FAIL midrun_restart_idx: got c1=%0d c4=%0d expected 0 1", vidx_at[1], vidx_at[4]);
    end
    checks++;
    if (done_cyc !== 25 || a_err !== 9'd0) begin
      failures++; $display("FAIL midrun_rerun: got done=%0d err=%0d expected 25 0", done_cyc, a_err);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_mode = 1'b0;
    a_ptr = 0; b_ptr = 0;
    load_rom(1'b0);
    present_a(); present_b();

    test_reset();
    test_all_match();
    test_injected();
    test_restart();
    test_back_pressure();
    test_settle_delay();
    test_settle_b();
    test_reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
